// File: rtl/riscv_instr_mem_responder.sv
// riscv_instr_mem_responder: responder end of the instruction-fetch interface.
// Word-organised memory with a preload port, in-order responses after a fixed
// grant-to-rvalid latency, and an outstanding-request cap on grants.
// Optional build macro RVALID_JITTER_EN: an 8-bit LFSR gates release of the
// response queue head, adding random extra latency without reordering.
module riscv_instr_mem_responder #(
  parameter int ADDR_WIDTH      = 12,
  parameter int RVALID_LATENCY  = 1,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  gnt_stall_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  output logic [CNT_W-1:0]      outstanding_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int QPW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [QPW-1:0]   Q_LAST  = QPW'(MAX_OUTSTANDING - 1);

  logic [31:0]               r_mem [DEPTH];
  logic [RVALID_LATENCY-1:0] r_dl_vld;
  logic [31:0]               r_dl_data [RVALID_LATENCY];
  logic [31:0]               r_q_data [MAX_OUTSTANDING];
  logic [QPW-1:0]            r_q_rd;
  logic [QPW-1:0]            r_q_wr;
  logic [CNT_W-1:0]          r_q_cnt;
  logic [CNT_W-1:0]          r_outst;
  logic [31:0]               r_rdata_hold;

  logic [ADDR_WIDTH-1:0]     w_idx;
  logic [31:0]               w_rd_word;
  logic                      w_gnt;
  logic                      w_release;
  logic                      w_q_empty;
  logic                      w_head_vld;
  logic [31:0]               w_head_data;
  logic                      w_rvalid;
  logic                      w_q_push;
  logic                      w_q_pop;
  logic                      w_unused;

  // Byte offset and address bits above the memory depth are don't-care.
  assign w_unused  = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0]};
  assign w_idx     = instr_addr_i[ADDR_WIDTH+1:2];
  assign w_rd_word = r_mem[w_idx];

`ifdef RVALID_JITTER_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4; bit 0 gates release of the queue head.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 8'hA5;
    else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_release = r_lfsr[0];
`else
  assign w_release = 1'b1;
`endif

  // The queue holds matured responses that could not be released yet; when it
  // is empty the delay-line tail is presented directly so latency stays exact.
  assign w_q_empty   = (r_q_cnt == '0);
  assign w_head_vld  = ~w_q_empty | r_dl_vld[RVALID_LATENCY-1];
  assign w_head_data = w_q_empty ? r_dl_data[RVALID_LATENCY-1] : r_q_data[r_q_rd];
  assign w_rvalid    = w_head_vld & w_release;
  assign w_q_pop     = ~w_q_empty & w_rvalid;
  assign w_q_push    = r_dl_vld[RVALID_LATENCY-1] & ~(w_q_empty & w_release);

  // A retiring response in the same cycle frees a slot at the limit.
  assign w_gnt = instr_req_i & ~gnt_stall_i & ~rst & ((r_outst < MAX_CNT) | w_rvalid);

  assign instr_gnt_o    = w_gnt;
  assign instr_rvalid_o = w_rvalid;
  assign instr_rdata_o  = w_rvalid ? w_head_data : r_rdata_hold;
  assign outstanding_o  = r_outst;

  // Preload port; contents survive reset. Reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  // Delay-line valid bits, cleared by reset so in-flight responses vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl_vld <= '0;
    end else begin
      r_dl_vld[0] <= w_gnt;
      for (int i = 1; i < RVALID_LATENCY; i++) r_dl_vld[i] <= r_dl_vld[i-1];
    end
  end

  // Delay-line data, captured from memory in the grant cycle.
  always_ff @(posedge clk) begin
    r_dl_data[0] <= w_rd_word;
    for (int i = 1; i < RVALID_LATENCY; i++) r_dl_data[i] <= r_dl_data[i-1];
  end

  // Response queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_rd  <= '0;
      r_q_wr  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_q_push) r_q_wr <= (r_q_wr == Q_LAST) ? '0 : r_q_wr + 1'b1;
      if (w_q_pop)  r_q_rd <= (r_q_rd == Q_LAST) ? '0 : r_q_rd + 1'b1;
      case ({w_q_push, w_q_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
        2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  // Response queue storage.
  always_ff @(posedge clk) begin
    if (w_q_push) r_q_data[r_q_wr] <= r_dl_data[RVALID_LATENCY-1];
  end

  // Outstanding count: +1 per grant, -1 per rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outst <= '0;
    end else begin
      case ({w_gnt, w_rvalid})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Last returned word is held on rdata while rvalid is low.
  always_ff @(posedge clk) begin
    if (rst)           r_rdata_hold <= '0;
    else if (w_rvalid) r_rdata_hold <= w_head_data;
  end

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Bench for riscv_instr_mem_responder: a queue-based reference model checks
// every cycle, directed scenarios add literal expectations.
module tb_riscv_instr_mem_responder;
  localparam int AW   = 12;
  localparam int L    = 3;
  localparam int MAXO = 2;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req_i;
  logic          instr_gnt_o;
  logic [31:0]   instr_addr_i;
  logic          instr_rvalid_o;
  logic [31:0]   instr_rdata_o;
  logic          gnt_stall_i;
  logic          we_i;
  logic [AW-1:0] waddr_i;
  logic [31:0]   wdata_i;
  logic [CW-1:0] outstanding_o;

  riscv_instr_mem_responder #(
    .ADDR_WIDTH(AW), .RVALID_LATENCY(L), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o),
    .instr_addr_i(instr_addr_i), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .gnt_stall_i(gnt_stall_i), .we_i(we_i),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .outstanding_o(outstanding_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: memory image, in-order queue of (data, grant cycle).
  logic [31:0] m_mem [2**AW];
  logic [31:0] q_data[$];
  int          q_cyc[$];
  int          m_outst = 0;
  logic [31:0] m_last  = '0;
  int          cyc     = 0;

  // Observations for the directed literal checks.
  logic [31:0] got[$];
  int          got_lat[$];
  int          rv_cnt   = 0;
  int          peak_out = 0;

  always @(negedge clk) begin
    logic exp_rv;
    logic exp_gnt;
    cyc++;
    if (rst) begin
      chk("gnt_in_reset", 32'(instr_gnt_o), 32'd0);
      q_data.delete();
      q_cyc.delete();
      m_outst = 0;
      m_last  = '0;
    end else begin
`ifdef RVALID_JITTER_EN
      exp_rv = instr_rvalid_o;
      if (exp_rv) begin
        chk("rvalid_has_pending", 32'(q_cyc.size() > 0), 32'd1);
        if (q_cyc.size() > 0) chk("latency_min", 32'(cyc >= q_cyc[0] + L), 32'd1);
      end
`else
      exp_rv = (q_cyc.size() > 0) && (q_cyc[0] + L == cyc);
`endif
      chk("rvalid", 32'(instr_rvalid_o), 32'(exp_rv));
      if (instr_rvalid_o) rv_cnt++;
      if (exp_rv && q_cyc.size() > 0) begin
        chk("rdata", instr_rdata_o, q_data[0]);
        got.push_back(instr_rdata_o);
        got_lat.push_back(cyc - q_cyc[0]);
        m_last = q_data[0];
        void'(q_data.pop_front());
        void'(q_cyc.pop_front());
      end else if (!instr_rvalid_o) begin
        chk("rdata_hold", instr_rdata_o, m_last);
      end
      chk("outstanding", 32'(outstanding_o), 32'(m_outst));
      if (int'(outstanding_o) > peak_out) peak_out = int'(outstanding_o);
      exp_gnt = instr_req_i && !gnt_stall_i && ((m_outst < MAXO) || exp_rv);
      chk("gnt", 32'(instr_gnt_o), 32'(exp_gnt));
      if (exp_gnt) begin
        q_data.push_back(m_mem[instr_addr_i[AW+1:2]]);
        q_cyc.push_back(cyc);
      end
      m_outst = m_outst + int'(exp_gnt) - int'(exp_rv);
    end
    if (we_i) m_mem[waddr_i] = wdata_i;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    instr_req_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    we_i    = 1'b1;
    waddr_i = AW'(idx);
    wdata_i = d;
    step();
    we_i    = 1'b0;
  endtask

  // Hold req until granted; optionally toggle stall randomly while waiting.
  task automatic fetch(input logic [31:0] a, input bit rnd_stall);
    int budget = 60;
    bit done   = 0;
    instr_req_i  = 1'b1;
    instr_addr_i = a;
    while (!done) begin
      gnt_stall_i = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      done = instr_gnt_o;
      step();
      we_i = 1'b0;
      if (!done && --budget == 0) begin
        n_total++;
        $display("FAIL fetch_timeout: addr %h not granted within 60 cycles", a);
        done = 1;
      end
    end
    instr_req_i = 1'b0;
    gnt_stall_i = 1'b0;
  endtask

  initial begin
    int gcount;
    rst = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; gnt_stall_i = 1'b0;
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rvalid", 32'(instr_rvalid_o), 32'd0);
    chk("reset_rdata", instr_rdata_o, 32'd0);
    chk("reset_outstanding", 32'(outstanding_o), 32'd0);
    step();

    preload(0, 32'h11); preload(1, 32'h22); preload(2, 32'h33); preload(3, 32'h44);
    for (int i = 4; i < 16; i++) preload(i, 32'hA000_0000 + i);

    // 1: back-to-back fetches of words 0..3, in order, fixed latency.
    got.delete(); got_lat.delete();
    fetch(32'h0, 0); fetch(32'h4, 0); fetch(32'h8, 0); fetch(32'hC, 0);
    idle(L + 3);
    chk("t1_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("t1_d0", got[0], 32'h11); chk("t1_d1", got[1], 32'h22);
      chk("t1_d2", got[2], 32'h33); chk("t1_d3", got[3], 32'h44);
`ifndef RVALID_JITTER_EN
      chk("t1_lat0", 32'(got_lat[0]), 32'd3);
      chk("t1_lat3", 32'(got_lat[3]), 32'd3);
`endif
    end

    // 2: stall for 3 cycles, redirect address 0x10 -> 0x20 during stall.
    got.delete();
    gcount = 0;
    instr_req_i = 1'b1; gnt_stall_i = 1'b1; instr_addr_i = 32'h10;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) instr_addr_i = 32'h20;
      if (c == 3) gnt_stall_i = 1'b0;
      @(negedge clk);
      if (instr_gnt_o) gcount++;
      step();
    end
    instr_req_i = 1'b0;
    idle(L + 3);
    chk("t2_gnt_count", 32'(gcount), 32'd1);
    chk("t2_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("t2_data", got[0], 32'hA000_0008);

    // 3: continuous requests saturate the outstanding limit.
    peak_out = 0;
    for (int i = 0; i < 6; i++) fetch(32'(i * 4), 0);
    idle(L + 3);
    chk("t3_peak", 32'(peak_out), 32'd2);

    // 4: halfword and wrapped addresses; read-before-write on preload.
    got.delete();
    fetch(32'h6, 0);
    fetch((32'd4 << AW) + 32'd4, 0);
    idle(L + 3);
    we_i = 1'b1; waddr_i = AW'(5); wdata_i = 32'hDEAD_BEEF;
    fetch(32'h14, 0);
    idle(L + 3);
    fetch(32'h14, 0);
    idle(L + 3);
    chk("t4_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("t4_half", got[0], 32'h22); chk("t4_wrap", got[1], 32'h22);
      chk("t4_old", got[2], 32'hA000_0005); chk("t4_new", got[3], 32'hDEAD_BEEF);
    end

    // 5: reset with two grants in flight drops both responses.
    fetch(32'h0, 0); fetch(32'h4, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rv_cnt = 0;
    idle(6);
    chk("t5_no_rvalid", 32'(rv_cnt), 32'd0);
    chk("t5_outstanding", 32'(outstanding_o), 32'd0);
    got.delete();
    fetch(32'h0, 0); fetch(32'h4, 0);
    idle(L + 3);
    chk("t5_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("t5_d0", got[0], 32'h11); chk("t5_d1", got[1], 32'h22);
    end

    // 6: random addresses (words 0..15, junk upper/low bits) with random stalls.
    peak_out = 0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) |
          32'($urandom_range(0, 3));
      fetch(a, 1);
    end
    idle(L + 40);
    chk("t6_peak_le_max", 32'(peak_out <= MAXO), 32'd1);
    chk("t6_drained", 32'(outstanding_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
